// File: rtl/sram_arbiter_if.sv
// Requester-side bus of the SRAM arbiter: the line-buffer writer (wr_*) and
// the interpolation pixel fetch (rd_*), plus the fixed-latency read return.
//
// Handshake: a transfer happens on the rising clk edge where valid && ready.
// The requester keeps addr/data stable while valid is high and not yet
// accepted. It may drop valid at any time, because nothing is locked.
// ready is combinational and never rises without its own valid.
// rd_rvalid/rd_rdata return two cycles after the read is accepted. This return
// path has no backpressure.
interface sram_arbiter_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 40
);

  logic                  wr_valid;
  logic                  wr_ready;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  logic                  rd_valid;
  logic                  rd_ready;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_rvalid;
  logic [DATA_WIDTH-1:0] rd_rdata;

  // Requester side: issues requests and consumes read data.
  modport master (
    output wr_valid, wr_addr, wr_data,
    input  wr_ready,
    output rd_valid, rd_addr,
    input  rd_ready, rd_rvalid, rd_rdata
  );

  // Arbiter side.
  modport slave (
    input  wr_valid, wr_addr, wr_data,
    output wr_ready,
    input  rd_valid, rd_addr,
    output rd_ready, rd_rvalid, rd_rdata
  );

endinterface

// File: rtl/sram_arbiter.sv
// Round-robin arbiter with a bounded burst. It shares one single-port SRAM
// macro (active-low CEN/WEN, 1-cycle registered read) between the line-buffer
// writer and the pixel fetch. The SRAM command is registered, and read data
// comes back with a fixed two-cycle valid strobe.
module sram_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 40,
  parameter int BURST      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  sram_arbiter_if.slave         req,
  output logic                  sram_cen,
  output logic                  sram_wen,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q,
  output logic                  prio_dbg,
  output logic [3:0]            cnt_dbg
);

  // The burst counter is 4 bits, so BURST must fit in 1..15.
  if (BURST < 1 || BURST > 15) begin : g_bad_burst
    $error("sram_arbiter: BURST must be in 1..15");
  end

  // When the counter reaches this value, the next contended grant hands
  // priority to the other side.
  localparam logic [3:0] BURST_LAST = 4'(BURST - 1);

  // Which requester wins when both are valid.
  typedef enum logic {
    PRIO_WR = 1'b0,
    PRIO_RD = 1'b1
  } prio_e;

  prio_e      prio_q, prio_d;
  logic [3:0] cnt_q,  cnt_d;
  logic       grant_wr;
  logic       grant_rd;

  // Fairness state register (priority owner and contended-grant count).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= PRIO_WR;
      cnt_q  <= 4'd0;
    end else begin
      prio_q <= prio_d;
      cnt_q  <= cnt_d;
    end
  end

  // Grant decision and next fairness state. The state moves only on a
  // granted cycle.
  always_comb begin
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    prio_d   = prio_q;
    cnt_d    = cnt_q;

    if (en) begin
      if (req.wr_valid && (!req.rd_valid || prio_q == PRIO_WR)) begin
        grant_wr = 1'b1;
      end else if (req.rd_valid) begin
        grant_rd = 1'b1;
      end
    end

    if (grant_wr) begin
      if (req.rd_valid) begin
        // Contended: count this grant. Yield once the burst is used up.
        if (cnt_q == BURST_LAST) begin
          prio_d = PRIO_RD;
          cnt_d  = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end else begin
        // Uncontended: the writer keeps priority with a fresh burst.
        prio_d = PRIO_WR;
        cnt_d  = 4'd0;
      end
    end else if (grant_rd) begin
      if (req.wr_valid) begin
        if (cnt_q == BURST_LAST) begin
          prio_d = PRIO_WR;
          cnt_d  = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end else begin
        prio_d = PRIO_RD;
        cnt_d  = 4'd0;
      end
    end
  end

  assign req.wr_ready = grant_wr;
  assign req.rd_ready = grant_rd;

  // Registered SRAM command. Address and data hold their last values when
  // idle, and a read leaves the write-data register untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_cen <= 1'b1;
      sram_wen <= 1'b1;
      sram_a   <= '0;
      sram_d   <= '0;
    end else if (grant_wr) begin
      sram_cen <= 1'b0;
      sram_wen <= 1'b0;
      sram_a   <= req.wr_addr;
      sram_d   <= req.wr_data;
    end else if (grant_rd) begin
      sram_cen <= 1'b0;
      sram_wen <= 1'b1;
      sram_a   <= req.rd_addr;
    end else begin
      sram_cen <= 1'b1;
      sram_wen <= 1'b1;
    end
  end

  // Read return strobe, one cycle behind the issued read command, aligned
  // with the macro's registered output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req.rd_rvalid <= 1'b0;
    end else begin
      req.rd_rvalid <= !sram_cen && sram_wen;
    end
  end

  assign req.rd_rdata = sram_q;

  assign prio_dbg = (prio_q == PRIO_RD);
  assign cnt_dbg  = cnt_q;

endmodule
